miner_controller_mc: RTL and testbench

MINER_CONTROLLER_MC -- requirements
Module: miner_controller_mc

---
 rtl/miner_pkg.sv | 22 ++
 rtl/miner_rr_arbiter.sv | 33 +++
 rtl/miner_controller_mc.sv | 210 +++++++++++++++++++++
 tb/tb_miner_controller_mc.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/miner_pkg.sv
// Shared types and constants for the miner job controller and its arbiter.
package miner_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_MID = 3'd1,
        ST_LOAD_REM = 3'd2,
        ST_SOLVE    = 3'd3,
        ST_HALT     = 3'd4
    } state_e;

    localparam logic [1:0] RESP_WAIT   = 2'b00;
    localparam logic [1:0] RESP_RESUME = 2'b01;

    // Width of an index into n items, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/miner_rr_arbiter.sv
// Round-robin picker: first requester above the last-granted index, wrapping around.
module miner_rr_arbiter
    import miner_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]          req,
    input  logic [idx_w(N)-1:0]   last,
    output logic [N-1:0]          grant,
    output logic [idx_w(N)-1:0]   idx,
    output logic                  any
);

    localparam int IW = idx_w(N);

    logic [IW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int i = 1; i <= N; i++) begin
            cand = IW'((int'(last) + i) % N);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/miner_controller_mc.sv
// Miner job controller: header load sequencing, solve enable and claim review.
// Optional HALT abandon timer enabled by defining MINER_HALT_TIMEOUT_EN.
module miner_controller_mc
    import miner_pkg::*;
#(
    parameter int NUM_CORES    = 4,
    parameter int MID_SHIFTS   = 8,
    parameter int REM_SHIFTS   = 4,
    parameter int HALT_TIMEOUT = 1024
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          start_found,
    input  logic                          shift_valid,
    input  logic [NUM_CORES-1:0]          sol_claim,
    input  logic [NUM_CORES-1:0]          core_exhausted,
    input  logic [1:0]                    sol_response,
    output logic [STATE_W-1:0]            state,
    output logic                          idleState,
    output logic                          midState,
    output logic                          headState,
    output logic                          solveState,
    output logic                          haltState,
    output logic [NUM_CORES-1:0]          core_run,
    output logic [NUM_CORES-1:0]          grant,
    output logic [idx_w(NUM_CORES)-1:0]   grant_idx,
    output logic                          no_solution,
    output logic                          halt_timeout
);

    localparam int IW   = idx_w(NUM_CORES);
    localparam int MAXS = (MID_SHIFTS > REM_SHIFTS) ? MID_SHIFTS : REM_SHIFTS;
    localparam int CW   = $clog2(MAXS + 1);
    localparam logic [CW-1:0] MID_LAST = CW'(MID_SHIFTS - 1);
    localparam logic [CW-1:0] REM_LAST = CW'(REM_SHIFTS - 1);

    if (NUM_CORES < 1 || NUM_CORES > 16 || MID_SHIFTS < 1 || REM_SHIFTS < 1 || HALT_TIMEOUT < 1) begin : g_bad_cfg
        $error("miner_controller_mc: parameter out of range");
    end

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NUM_CORES-1:0]  pend_q, pend_d;
    logic [NUM_CORES-1:0]  grant_q, grant_d;
    logic [IW-1:0]         gidx_q, gidx_d;
    logic [IW-1:0]         last_q, last_d;
    logic                  nosol_q, nosol_d;
    logic                  tout_q, tout_d;

`ifdef MINER_HALT_TIMEOUT_EN
    localparam int TW = idx_w(HALT_TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(HALT_TIMEOUT - 1);
    logic [TW-1:0] tcnt_q, tcnt_d;
`endif

    logic [NUM_CORES-1:0]  pend_in;
    logic [NUM_CORES-1:0]  arb_gnt;
    logic [IW-1:0]         arb_idx;
    logic                  arb_any;

    assign pend_in = pend_q | sol_claim;

    miner_rr_arbiter #(.N(NUM_CORES)) u_arb (
        .req   (pend_in),
        .last  (last_q),
        .grant (arb_gnt),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        nosol_d = 1'b0;
        tout_d  = 1'b0;
`ifdef MINER_HALT_TIMEOUT_EN
        tcnt_d  = tcnt_q;
`endif
        if (start_found) begin
            state_d = ST_LOAD_MID;
            cnt_d   = '0;
            pend_d  = '0;
            grant_d = '0;
            gidx_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_LOAD_MID: if (shift_valid) begin
                    if (cnt_q == MID_LAST) begin
                        state_d = ST_LOAD_REM;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_LOAD_REM: if (shift_valid) begin
                    if (cnt_q == REM_LAST) begin
                        state_d = ST_SOLVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_SOLVE: begin
                    pend_d = pend_in;
                    // A claim outranks exhaustion arriving in the same cycle.
                    if (arb_any) begin
                        state_d = ST_HALT;
                        grant_d = arb_gnt;
                        gidx_d  = arb_idx;
                        last_d  = arb_idx;
                        pend_d  = pend_in & ~arb_gnt;
`ifdef MINER_HALT_TIMEOUT_EN
                        tcnt_d  = '0;
`endif
                    end else if (&core_exhausted) begin
                        state_d = ST_IDLE;
                        nosol_d = 1'b1;
                    end
                end
                ST_HALT: begin
                    pend_d = pend_in;
                    case (sol_response)
                        RESP_WAIT: begin
`ifdef MINER_HALT_TIMEOUT_EN
                            if (tcnt_q == T_LAST) begin
                                state_d = ST_IDLE;
                                pend_d  = '0;
                                grant_d = '0;
                                gidx_d  = '0;
                                tout_d  = 1'b1;
                            end else begin
                                tcnt_d = tcnt_q + 1'b1;
                            end
`endif
                        end
                        RESP_RESUME: begin
                            state_d = ST_SOLVE;
                            grant_d = '0;
                            gidx_d  = '0;
                        end
                        default: begin
                            state_d = ST_IDLE;
                            pend_d  = '0;
                            grant_d = '0;
                            gidx_d  = '0;
                        end
                    endcase
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    pend_d  = '0;
                    grant_d = '0;
                    gidx_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= IW'(NUM_CORES - 1);
            nosol_q <= 1'b0;
            tout_q  <= 1'b0;
`ifdef MINER_HALT_TIMEOUT_EN
            tcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            nosol_q <= nosol_d;
            tout_q  <= tout_d;
`ifdef MINER_HALT_TIMEOUT_EN
            tcnt_q  <= tcnt_d;
`endif
        end
    end

    assign state      = state_q;
    assign midState   = (state_q == ST_LOAD_MID);
    assign headState  = (state_q == ST_LOAD_REM);
    assign solveState = (state_q == ST_SOLVE);
    assign haltState  = (state_q == ST_HALT);
    // Illegal encodings read as idle so exactly one decode is ever high.
    assign idleState  = ~(midState | headState | solveState | haltState);
    assign core_run   = {NUM_CORES{solveState}};
    assign grant      = grant_q;
    assign grant_idx  = gidx_q;
    assign no_solution = nosol_q;
`ifdef MINER_HALT_TIMEOUT_EN
    assign halt_timeout = tout_q;
`else
    assign halt_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_miner_controller_mc.sv
// Directed self-checking bench for miner_controller_mc (4 cores, 8+4 beats, 16-cycle halt timeout).
module tb_miner_controller_mc;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       start_found = 1'b0;
    logic       shift_valid = 1'b0;
    logic [3:0] sol_claim = 4'h0;
    logic [3:0] core_exhausted = 4'h0;
    logic [1:0] sol_response = 2'b00;
    logic [2:0] state;
    logic       idleState, midState, headState, solveState, haltState;
    logic [3:0] core_run;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       no_solution;
    logic       halt_timeout;

    int checks = 0;
    int errors = 0;
    logic seen_to;

    miner_controller_mc #(
        .NUM_CORES(4), .MID_SHIFTS(8), .REM_SHIFTS(4), .HALT_TIMEOUT(16)
    ) dut (
        .clk(clk), .n_rst(n_rst), .start_found(start_found), .shift_valid(shift_valid),
        .sol_claim(sol_claim), .core_exhausted(core_exhausted), .sol_response(sol_response),
        .state(state), .idleState(idleState), .midState(midState), .headState(headState),
        .solveState(solveState), .haltState(haltState), .core_run(core_run),
        .grant(grant), .grant_idx(grant_idx), .no_solution(no_solution),
        .halt_timeout(halt_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int beats);
        start_found = 1'b1;
        tick();
        start_found = 1'b0;
        shift_valid = 1'b1;
        repeat (beats) tick();
        shift_valid = 1'b0;
    endtask

    initial begin
        #22;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_idle_dec", 32'(idleState), 32'd1);
        chk("rst_core_run", 32'(core_run), 32'h0);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_grant_idx", 32'(grant_idx), 32'h0);
        chk("rst_pulses", 32'({no_solution, halt_timeout}), 32'h0);
        n_rst = 1'b1;
        tick();
        chk("post_rst_pulses", 32'({no_solution, halt_timeout}), 32'h0);

        // Full header load: LOAD_REM after 8 beats, SOLVE exactly on the 12th.
        start_found = 1'b1;
        tick();
        start_found = 1'b0;
        chk("start_mid", 32'(state), 32'd1);
        shift_valid = 1'b1;
        repeat (7) tick();
        chk("mid_7beats", 32'(state), 32'd1);
        tick();
        chk("rem_8beats", 32'(state), 32'd2);
        chk("rem_dec", 32'(headState), 32'd1);
        repeat (3) tick();
        chk("rem_11beats", 32'(state), 32'd2);
        chk("rem_core_run", 32'(core_run), 32'h0);
        tick();
        chk("solve_12beats", 32'(state), 32'd3);
        chk("solve_core_run", 32'(core_run), 32'hF);
        chk("solve_dec", 32'({idleState, midState, headState, solveState, haltState}), 32'b00010);
        tick();
        shift_valid = 1'b0;
        chk("solve_ignores_shift", 32'(state), 32'd3);

        // Claim 1010 with last pointer 3 -> core 1 first, then core 3 from pending.
        sol_claim = 4'b1010;
        tick();
        sol_claim = 4'b0000;
        chk("claim_halt", 32'(state), 32'd4);
        chk("claim_grant", 32'(grant), 32'b0010);
        chk("claim_idx", 32'(grant_idx), 32'd1);
        chk("halt_core_run", 32'(core_run), 32'h0);
        tick();
        chk("halt_wait", 32'(state), 32'd4);
        sol_response = 2'b01;
        tick();
        sol_response = 2'b00;
        chk("resume_solve", 32'(state), 32'd3);
        chk("resume_grant0", 32'(grant), 32'h0);
        tick();
        chk("pending_halt", 32'(state), 32'd4);
        chk("pending_grant", 32'(grant), 32'b1000);
        chk("pending_idx", 32'(grant_idx), 32'd3);
        sol_response = 2'b10;
        tick();
        sol_response = 2'b00;
        chk("accept_idle", 32'(state), 32'd0);
        chk("accept_grant0", 32'(grant), 32'h0);

        // Exhaustion with no claim.
        load(12);
        chk("reload_solve", 32'(state), 32'd3);
        core_exhausted = 4'hF;
        tick();
        chk("exh_idle", 32'(state), 32'd0);
        chk("exh_pulse", 32'(no_solution), 32'd1);
        tick();
        core_exhausted = 4'h0;
        chk("exh_pulse_end", 32'(no_solution), 32'd0);

        // Claim beats exhaustion in the same cycle; pointer 3 -> core 0.
        load(12);
        core_exhausted = 4'hF;
        sol_claim = 4'b0101;
        tick();
        core_exhausted = 4'h0;
        sol_claim = 4'b0000;
        chk("claim_wins_state", 32'(state), 32'd4);
        chk("claim_wins_grant", 32'(grant), 32'b0001);
        chk("claim_wins_nosol", 32'(no_solution), 32'd0);

        // start_found during HALT drops grant and the pending claim for core 2.
        start_found = 1'b1;
        tick();
        start_found = 1'b0;
        chk("halt_start_mid", 32'(state), 32'd1);
        chk("halt_start_grant", 32'(grant), 32'h0);
        chk("halt_start_idx", 32'(grant_idx), 32'd0);
        shift_valid = 1'b1;
        repeat (12) tick();
        shift_valid = 1'b0;
        chk("halt_start_solve", 32'(state), 32'd3);
        tick();
        chk("pending_cleared", 32'(state), 32'd3);
        chk("pending_cleared_grant", 32'(grant), 32'h0);

        // Halt with response held at 00; pointer 0 -> claim 0010 grants core 1.
        sol_claim = 4'b0010;
        tick();
        sol_claim = 4'b0000;
        chk("to_halt", 32'(state), 32'd4);
        chk("to_grant", 32'(grant), 32'b0010);
        seen_to = 1'b0;
`ifdef MINER_HALT_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            tick();
            seen_to = seen_to | halt_timeout;
        end
        chk("to_still_halt_15", 32'(state), 32'd4);
        chk("to_no_early_pulse", 32'(seen_to), 32'd0);
        tick();
        chk("to_idle_16", 32'(state), 32'd0);
        chk("to_pulse", 32'(halt_timeout), 32'd1);
        chk("to_grant0", 32'(grant), 32'h0);
        tick();
        chk("to_pulse_end", 32'(halt_timeout), 32'd0);
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            seen_to = seen_to | halt_timeout;
        end
        chk("no_to_still_halt", 32'(state), 32'd4);
        chk("no_to_pulse", 32'(seen_to), 32'd0);
        sol_response = 2'b11;
        tick();
        sol_response = 2'b00;
        chk("no_to_accept_idle", 32'(state), 32'd0);
`endif

        // Asynchronous reset mid-load discards beat progress.
        load(3);
        chk("rst_mid_loading", 32'(state), 32'd1);
        #2;
        n_rst = 1'b0;
        #1;
        chk("rst_async_idle", 32'(state), 32'd0);
        chk("rst_async_dec", 32'(midState), 32'd0);
        #3;
        n_rst = 1'b1;
        tick();
        chk("rst_release_pulses", 32'({no_solution, halt_timeout}), 32'h0);
        load(11);
        chk("rst_reload_11", 32'(state), 32'd2);
        shift_valid = 1'b1;
        tick();
        shift_valid = 1'b0;
        chk("rst_reload_12", 32'(state), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
